// File: rtl/pipe_hazard_ctrl.sv
// ID/EX sequencing controller: load-use bubbles, IF/ID flush on taken branch,
// whole-pipeline freeze for multi-cycle data-memory accesses, and a lost-issue counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             ifid_uses_rt_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic             branch_taken_i,
  input  logic             exmem_memreq_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             freeze_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [1:0]       state_o
);

  localparam int unsigned       WCNT_W    = 4;
  localparam bit                MULTI_CYC = (MEM_LAT > 1);
  localparam int unsigned       WLOAD_I   = MULTI_CYC ? MEM_LAT - 2 : 0;
  localparam logic [WCNT_W-1:0] WLOAD     = WCNT_W'(WLOAD_I);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1
  } state_e;

  state_e              state_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic                freeze_c;
  logic                luse_c;

  // Freeze: the first access cycle is caught in RUN, the rest are counted down in MEM_WAIT.
  always_comb begin
    freeze_c = 1'b0;
    if (rst_n) begin
      if (state_q == RUN) freeze_c = exmem_memreq_i && MULTI_CYC;
      else                freeze_c = (wcnt_q != '0);
    end
  end

  assign luse_c = idex_memread_i && (idex_rt_i != 5'd0) &&
                  ((idex_rt_i == ifid_rs_i) || (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));

  // Control outputs, priority freeze > load-use > branch; all inactive in reset.
  always_comb begin
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    freeze_o      = freeze_c;
    if (rst_n && !freeze_c) begin
      if (luse_c) begin
        idex_bubble_o = 1'b1;
      end else begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        ifid_flush_o = branch_taken_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wcnt_q      <= '0;
      stall_cnt_o <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (freeze_c) begin
            state_q <= MEM_WAIT;
            wcnt_q  <= WLOAD;
          end
        end
        MEM_WAIT: begin
          if (wcnt_q != '0) wcnt_q  <= wcnt_q - WCNT_W'(1);
          else              state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
      // Lost issue cycles saturate rather than wrap.
      if (!pc_write_o && (stall_cnt_o != CNT_MAX))
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

  assign state_o = state_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the ID/EX stage of the 5-stage MIPS core.
- Detects load-use hazards and selects the bubble (zero control word) into the ID/EX control fields.
- Flushes IF/ID on a taken branch.
- Freezes the whole pipeline while a multi-cycle data-memory access completes in MEM.
- Keeps a saturating count of lost issue cycles.

Parameters:
MEM_LAT, 2, total cycles a data-memory access occupies MEM; legal range 1..16.
CNT_W, 16, width of the stall cycle counter.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
ifid_rs_i  input  5  rs field of the instruction in IF/ID
ifid_rt_i  input  5  rt field of the instruction in IF/ID
ifid_uses_rt_i  input  1  the IF/ID instruction reads rt (R-type, beq, sw)
idex_memread_i  input  1  ID/EX holds a load
idex_rt_i  input  5  destination rt of the ID/EX instruction
branch_taken_i  input  1  branch in ID resolved taken this cycle
exmem_memreq_i  input  1  EX/MEM holds a load or store
pc_write_o  output  1  PC update enable
ifid_write_o  output  1  IF/ID load enable
ifid_flush_o  output  1  IF/ID clears to NOP at the next edge
idex_bubble_o  output  1  selects the zero control word into the ID/EX control fields
freeze_o  output  1  holds ID/EX, EX/MEM and MEM/WB
stall_cnt_o  output  CNT_W  saturating count of cycles with pc_write_o=0
state_o  output  2  FSM state: 0 RUN, 1 MEM_WAIT

Behaviour:
- FSM states are RUN and MEM_WAIT. Internal down-counter wcnt is 4 bits.
- Reset (rst_n=0 at an edge): state=RUN, wcnt=0, stall_cnt_o=0.
- While rst_n=0, all combinational outputs are forced inactive: pc_write_o=0, ifid_write_o=0, flush=0, bubble=0, freeze=0.
- freeze (combinational):
  - RUN: freeze = exmem_memreq_i && MEM_LAT>1.
  - MEM_WAIT: freeze = (wcnt!=0). exmem_memreq_i is ignored.
- Transitions:
  - RUN -> MEM_WAIT when the RUN freeze term is 1; load wcnt=MEM_LAT-2.
  - MEM_WAIT with wcnt!=0: decrement wcnt.
  - MEM_WAIT with wcnt==0: go to RUN. The pipeline advances this cycle.
  - Result: MEM_LAT-1 frozen cycles per access.
  - MEM_LAT=1: the FSM never leaves RUN and freeze stays 0.
- Load-use (luse, combinational) = idex_memread_i && idex_rt_i!=0 && (idex_rt_i==ifid_rs_i || (ifid_uses_rt_i && idex_rt_i==ifid_rt_i)).
- Priority is freeze > luse > branch:
  - freeze=1: pc_write=0, ifid_write=0, bubble=0, flush=0. Hazard work is deferred, not lost.
  - else luse=1: pc_write=0, ifid_write=0, bubble=1, flush=0. The branch is re-evaluated the next cycle.
  - else branch_taken_i=1: pc_write=1, ifid_write=1, flush=1, bubble=0.
  - else: pc_write=1, ifid_write=1, flush=0, bubble=0.
- Latency: all control outputs are combinational, valid in the same cycle as their inputs. state_o and stall_cnt_o are registered.
- stall_cnt_o increments by 1 at each edge where rst_n=1 and pc_write_o=0, then holds at 2^CNT_W-1 (no wrap).
- Reset mid-MEM_WAIT aborts the wait: RUN and freeze=0 from the next cycle.
- Back-to-back memory ops: the RUN cycle after MEM_WAIT re-evaluates exmem_memreq_i, so the next access re-enters MEM_WAIT immediately.

Test Plan:
1. Load-use. idex_memread=1, idex_rt=8, ifid_rs=8, MEM_LAT=1. Required: pc_write=0, ifid_write=0, bubble=1 for 1 cycle; stall_cnt 0->1. With idex_rt=0 there is no stall.
2. rt-only dependency. ifid_rt=8 with ifid_uses_rt=0 gives no stall; with ifid_uses_rt=1, bubble=1.
3. Taken branch. branch_taken=1, no hazard. Required: flush=1, pc_write=1 for 1 cycle. Load-use and branch together: bubble=1, flush=0.
4. Memory wait, MEM_LAT=4. exmem_memreq=1 held. Required: freeze=1 for exactly 3 cycles, state_o sequence 0,1,1,1,0, stall_cnt +3. With luse also asserted, bubble=0 while freeze=1.
5. Reset mid-wait. rst_n=0 on the 2nd frozen cycle. Required: all outputs inactive during reset; after release state=0, freeze=0, stall_cnt=0.
6. Saturation. CNT_W=4, hold a continuous load-use stall for 20 cycles. Required: stall_cnt_o stops at 15.
